// File: rtl/serial_crc8_checker.sv
// Bit-serial CRC-8 accumulator and frame checker.
// Folds each accepted bit into a CRC register, delimits frames with a last
// marker and reports CRC, saturated length and a zero-residue flag one cycle
// after each frame ends.
module serial_crc8_checker #(
  parameter logic [7:0] POLY = 8'h07,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       busy,
  output logic       out_valid,
  output logic [7:0] out_crc,
  output logic [7:0] out_len,
  output logic       out_ok
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t     state_q;
  logic [7:0] crc_q;
  logic [7:0] len_q;
  logic [7:0] crc_d;
  logic [7:0] len_d;
  logic       fb;
  logic       busy_q;
  logic       out_valid_q;
  logic [7:0] out_crc_q;
  logic [7:0] out_len_q;
  logic       out_ok_q;

  // Next CRC and saturated next length for the bit currently presented.
  always_comb begin
    fb    = crc_q[7] ^ in_bit;
    crc_d = {crc_q[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
    len_d = (len_q == 8'hFF) ? 8'hFF : len_q + 8'd1;
  end

  // Frame FSM with registered outputs; reset discards any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      len_q       <= 8'h00;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_crc_q   <= 8'h00;
      out_len_q   <= 8'h00;
      out_ok_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (in_valid) begin
        if (in_last) begin
          // Completion: publish results and restart from INIT for a
          // possible back-to-back frame on the very next cycle.
          out_valid_q <= 1'b1;
          out_crc_q   <= crc_d;
          out_len_q   <= len_d;
          out_ok_q    <= (crc_d == 8'h00);
          crc_q       <= INIT;
          len_q       <= 8'h00;
          state_q     <= IDLE;
          busy_q      <= 1'b0;
        end else begin
          crc_q   <= crc_d;
          len_q   <= len_d;
          state_q <= RUN;
          busy_q  <= 1'b1;
        end
      end
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_crc   = out_crc_q;
  assign out_len   = out_len_q;
  assign out_ok    = out_ok_q;

endmodule

// File: doc/serial_crc8_checker.md
# serial_crc8_checker

Bit-serial CRC-8 accumulator and frame checker that consumes the single-bit output of the XOR/mux combinational stage. It folds each accepted bit into a CRC register with a feedback XOR, delimits frames with a `last` marker, and reports the final CRC, the frame length and a pass flag one cycle after each frame ends. It is the sequential consumer at the end of the combinational XOR chain.

## Interface

- `POLY`, 8'h07, CRC-8 generator polynomial, x^8 term implicit.
- `INIT`, 8'h00, CRC register value at reset and at the start of every frame.

- `clk`  input  1  rising-edge clock, the only clock.
- `rst`  input  1  reset, asynchronous and active-high.
- `in_valid`  input  1  `in_bit`/`in_last` are valid this cycle; the block accepts them unconditionally.
- `in_bit`  input  1  serial data bit, MSB of each byte first.
- `in_last`  input  1  qualified by `in_valid`; this bit is the final bit of the frame.
- `busy`  output  1  high while a frame is in progress, i.e. at least one bit accepted and `last` not yet seen.
- `out_valid`  output  1  one-cycle pulse: a frame has completed.
- `out_crc`  output  8  final CRC of the completed frame; held until the next completion.
- `out_len`  output  8  accepted bits in the completed frame, saturating at 255; held.
- `out_ok`  output  1  `out_crc == 0` (residue check when the frame carries its own CRC); held.

## Operation

- Two states: IDLE (CRC register = INIT, length = 0) and RUN.
- Accepted bit = `in_valid` high on a rising edge of `clk`. With `in_valid` low, all state holds.
- Per accepted bit: `fb = crc[7] ^ in_bit`; `crc_next = {crc[6:0], 1'b0} ^ (fb ? POLY : 8'h00)`. All arithmetic is 8 bits.
- Length counter: +1 per accepted bit, saturating at 255. It never wraps.
- Accepted bit with `in_last` = 0: the CRC and length update, and the state goes to RUN (from IDLE or RUN).
- Accepted bit with `in_last` = 1 (including the first bit of a frame):
  - `out_crc` <= `crc_next`.
  - `out_len` <= saturated length + 1.
  - `out_ok` <= (`crc_next` == 0).
  - `out_valid` <= 1.
  - The CRC register returns to INIT, the length to 0, and the state to IDLE.
- `in_last` with `in_valid` low is ignored.
- `busy` = (state == RUN).
- Back-to-back frames: a bit accepted in the cycle directly after a `last` bit starts a new frame from INIT. No bubble is required.
- No backpressure: the producer may present a bit on every cycle.

## Timing

- Reset values: `busy` = 0, `out_valid` = 0, `out_crc` = 8'h00, `out_len` = 8'h00, `out_ok` = 0.
- Reset also sets the internal CRC register to INIT, the length to 0 and the state to IDLE.
- Reset takes effect immediately, with no clock needed, and wins over any simultaneous input.
- Reset mid-frame discards the partial frame. No `out_valid` is produced for it.
- Latency: `out_valid` and the result fields update on the same edge that accepts the `last` bit, so they are visible in the following cycle.
- `out_valid` is high for exactly one cycle per frame, then drops to 0 unless another `last` bit is accepted on that edge.
- Result fields change only on a completion edge or on reset.
- `busy` rises in the cycle after the first non-last bit is accepted and falls in the cycle after `last` is accepted.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- ASCII "123456789" (72 bits, MSB first, `in_valid` every cycle, `in_last` on bit 72) -> one `out_valid` pulse; `out_crc` = 8'hF4, `out_len` = 72, `out_ok` = 0; `busy` high over bits 1..71.
- The same 72 bits followed by 8'hF4 (80 bits, `last` on bit 80) -> `out_crc` = 8'h00, `out_len` = 80, `out_ok` = 1.
- Single-bit frames back to back: bit 1 with last, then bit 0 with last, on consecutive cycles -> two consecutive `out_valid` pulses:
  - first pulse: `out_crc` = 8'h07, `out_len` = 1, `out_ok` = 0;
  - second pulse: `out_crc` = 8'h00, `out_len` = 1, `out_ok` = 1;
  - `busy` stays 0 throughout.
- "123456789" with random `in_valid` gaps of 0–5 cycles, and `in_last` toggled during gaps -> identical result to the first scenario (8'hF4, 72); no spurious `out_valid`.
- 300 zero bits, `last` on bit 300 -> `out_len` = 255 (saturated), `out_crc` = 8'h00, `out_ok` = 1.
- `rst` pulsed asynchronously after 40 bits of "123456789":
  - all outputs return to their reset values at once and no pulse is produced;
  - a fresh full "123456789" frame afterwards gives 8'hF4, 72.
